// File: rtl/ps2_pkg.sv
// Shared constants and decoder state type for the PS/2 keyboard receiver.
package ps2_pkg;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic {IDLE, BRK} dec_state_e;
endpackage

// File: rtl/ps2_keyboard_if.sv
// PS/2 pins in, decoded key stream out; master is the receiver, slave its user.
interface ps2_keyboard_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       en;
    logic       key_down;
    logic [7:0] press_cnt;
    logic       overflow;
    logic       frame_err;

    modport master (input ps2_clk, ps2_data,
                    output keycode, en, key_down, press_cnt, overflow, frame_err);
    modport slave  (output ps2_clk, ps2_data,
                    input keycode, en, key_down, press_cnt, overflow, frame_err);
endinterface

// File: rtl/ps2_fifo.sv
// Synchronous byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_wr, do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];
    // Fullness is judged before the same-cycle pop, so a push into a full FIFO is lost.
    assign do_wr = push && !full;
    assign do_rd = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: sync, deserialize/check frames, buffer bytes, decode make/break.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic            clk,
    input logic            rst,
    ps2_keyboard_if.master bus
);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]                clk_sync, dat_sync;
    logic                      fall, sdat;
    logic [3:0]                bitcnt;
    logic [PS2_FRAME_BITS-1:0] frame, frame_nxt;
    logic [IW-1:0]             idle_cnt;
    logic                      last_bit, frame_ok, push, timeout;
    logic                      pop, full, empty;
    logic [7:0]                fifo_dout;
    logic                      overflow_q, frame_err_q;

    dec_state_e                state, state_nxt;
    logic                      take_press, take_release;
    logic [7:0]                keycode_q, press_cnt_q;
    logic                      en_q, key_down_q;

    // Bit 0 is the newest sample; an edge is seen between bits 2 (older) and 1 (newer).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], bus.ps2_clk};
            dat_sync <= {dat_sync[1:0], bus.ps2_data};
        end
    end

    assign fall      = clk_sync[2] && !clk_sync[1];
    assign sdat      = dat_sync[1];
    assign frame_nxt = {sdat, frame[PS2_FRAME_BITS-1:1]};
    assign frame_ok  = !frame_nxt[0] && frame_nxt[10] && (^frame_nxt[9:1]);
    assign last_bit  = fall && (bitcnt == 4'(PS2_FRAME_BITS - 1));
    assign push      = last_bit && frame_ok;
    assign timeout   = (bitcnt != 4'd0) && (idle_cnt == IW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt      <= '0;
            frame       <= '0;
            idle_cnt    <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (fall) begin
                idle_cnt <= '0;
                frame    <= frame_nxt;
                bitcnt   <= last_bit ? 4'd0 : bitcnt + 4'd1;
            end else begin
                if (idle_cnt != IW'(TIMEOUT_CYC)) idle_cnt <= idle_cnt + 1'b1;
                // A stalled partial frame is discarded quietly, not flagged as an error.
                if (timeout) bitcnt <= '0;
            end
            if (last_bit && !frame_ok) frame_err_q <= 1'b1;
            if (push && full)          overflow_q  <= 1'b1;
        end
    end

    ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (frame_nxt[8:1]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign pop = !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        take_press   = 1'b0;
        take_release = 1'b0;
        if (pop) begin
            case (state)
                IDLE: begin
                    if (fifo_dout == PS2_BRK)
                        state_nxt = BRK;
                    else if (fifo_dout != PS2_EXT && !(key_down_q && fifo_dout == keycode_q))
                        take_press = 1'b1;
                end
                BRK: begin
                    state_nxt    = IDLE;
                    take_release = (fifo_dout == keycode_q);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keycode_q   <= '0;
            press_cnt_q <= '0;
            en_q        <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            en_q <= take_press;
            if (take_press) begin
                keycode_q   <= fifo_dout;
                key_down_q  <= 1'b1;
                press_cnt_q <= press_cnt_q + 8'd1;
            end else if (take_release) begin
                key_down_q  <= 1'b0;
            end
        end
    end

    assign bus.keycode   = keycode_q;
    assign bus.en        = en_q;
    assign bus.key_down  = key_down_q;
    assign bus.press_cnt = press_cnt_q;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Drives PS/2 frames into ps2_keyboard and compares against a byte-level key model.
module tb_ps2_keyboard;
    import ps2_pkg::*;

    localparam int TMO = 200;
    localparam int HB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_keyboard_if bus ();

    ps2_keyboard #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vecs = 0;
    int         errs = 0;
    int         en_cnt = 0;
    logic [7:0] en_q [$];

    logic [7:0] m_kc, m_cnt;
    bit         m_kd, m_brk, m_ovf, m_ferr;
    int         m_en = 0;

    always @(negedge clk) begin
        if (bus.en === 1'b1) begin
            en_cnt++;
            en_q.push_back(bus.keycode);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_kc = 8'h00; m_cnt = 8'h00; m_kd = 0; m_brk = 0; m_ovf = 0; m_ferr = 0;
    endtask

    // Key semantics applied one received byte at a time.
    task automatic m_byte(input logic [7:0] b);
        if (m_brk) begin
            if (b == m_kc) m_kd = 0;
            m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
        end else if (!(m_kd && b == m_kc)) begin
            m_kc = b; m_kd = 1; m_cnt = m_cnt + 8'd1; m_en++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = fr[i];
            wait_clk(HB);
            bus.ps2_clk = 1'b0;
            wait_clk(HB);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit to_model);
        logic       par;
        logic [7:0] bb;
        bb  = b;
        par = (~(^bb)) ^ bad_par;
        send_bits({~bad_stop, par, bb, 1'b0}, 11);
        wait_clk(8);
        if (to_model) begin
            if (bad_par || bad_stop) m_ferr = 1;
            else                     m_byte(b);
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".keycode"},   32'(bus.keycode),   32'(m_kc));
        chk({t, ".key_down"},  32'(bus.key_down),  32'(m_kd));
        chk({t, ".press_cnt"}, 32'(bus.press_cnt), 32'(m_cnt));
        chk({t, ".en_pulses"}, 32'(en_cnt),        32'(m_en));
        chk({t, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        chk({t, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        m_reset();
        wait_clk(3);
        rst = 1'b1;
        wait_clk(2);
    endtask

    logic [7:0] pool [6] = '{8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hE0, 8'h2B};

    initial begin
        int n;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        m_reset();
        wait_clk(3);
        check_all("reset");
        en_cnt = 0;
        rst = 1'b1;
        wait_clk(2);

        send_frame(8'h1C, 0, 0, 1);
        check_all("make");
        send_frame(8'hF0, 0, 0, 1);
        send_frame(8'h1C, 0, 0, 1);
        check_all("break");
        send_frame(8'hE0, 0, 0, 1);
        send_frame(8'h75, 0, 0, 1);
        check_all("ext_make");

        do_reset();
        for (int i = 0; i < 3; i++) send_frame(8'h16, 0, 0, 1);
        check_all("typematic");

        do_reset();
        send_frame(8'h1C, 1, 0, 1);
        send_frame(8'h1C, 0, 1, 1);
        check_all("bad_frame");
        chk("bad_frame.fifo_empty", 32'(dut.empty), 32'd1);
        send_frame(8'h1E, 0, 0, 1);
        check_all("after_bad");

        do_reset();
        send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 6);
        wait_clk(TMO + 5);
        send_frame(8'h24, 0, 0, 1);
        check_all("timeout");

        send_bits({1'b1, 1'b0, 8'h3C, 1'b0}, 5);
        rst = 1'b0;
        m_reset();
        wait_clk(2);
        check_all("rst_mid_frame");
        rst = 1'b1;
        wait_clk(2);

        send_frame(8'hF0, 0, 0, 1);
        do_reset();
        send_frame(8'h1C, 0, 0, 1);
        check_all("rst_mid_seq");

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            bit bad;
            b   = pool[$urandom_range(0, 5)];
            bad = ($urandom_range(0, 9) == 0);
            send_frame(b, bad, 0, 1);
            check_all("random");
        end

        do_reset();
        force dut.pop = 1'b0;
        for (int i = 0; i < 9; i++) send_frame(8'h30 + 8'(i), 0, 0, 0);
        chk("ovf.flag", 32'(bus.overflow), 32'd1);
        chk("ovf.no_en_while_held", 32'(en_cnt), 32'(m_en));
        release dut.pop;
        wait_clk(12);
        m_ovf = 1;
        for (int i = 0; i < 8; i++) m_byte(8'h30 + 8'(i));
        check_all("ovf_drain");
        n = en_q.size();
        if (n >= 8) begin
            for (int i = 0; i < 8; i++)
                chk("ovf.order", 32'(en_q[n-8+i]), 32'(8'h30 + 8'(i)));
        end else begin
            chk("ovf.en_count", 32'(n), 32'd8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
